bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter using the iterative shift-and-add-3 (double dabble) algorithm.
- Converts an IN_WIDTH-bit unsigned value into DIGITS packed BCD nibbles over IN_WIDTH shift cycles.
- Uses a valid/ready handshake on both input and output.
- Sits between the angle/measurement datapath and the display/UART formatting logic.

Parameters:
- IN_WIDTH, 8: width of the unsigned binary input (legal range 1..32).
- DIGITS, 3: number of BCD output digits (legal range 1..10). Need not cover the full input range; see overflow_out.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset; one clock; reset is synchronous and active-low.
- bin_in  input  IN_WIDTH  unsigned value to convert.
- valid_in  input  1  bin_in is valid.
- ready_out  output  1  block can accept a new value.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0].
- overflow_out  output  1  bin_in was >= 10^DIGITS; bcd_out holds value mod 10^DIGITS.
- valid_out  output  1  bcd_out/overflow_out are valid.
- ready_in  input  1  downstream accepts the result.

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset (rst_n_in low at a clk_in edge):
  - state goes to IDLE.
  - bcd_out = 0, overflow_out = 0, valid_out = 0.
  - Internal shift register and iteration counter are cleared.
  - ready_out = (state == IDLE), so it reads 1 after the first reset edge.
  - Reset overrides everything, including mid-SHIFT and DONE; the in-flight conversion is discarded and no valid_out is produced.
- IDLE:
  - On valid_in && ready_out: capture bin_in into the shift register, clear the BCD scratch register, and set the counter to IN_WIDTH.
  - Register overflow = (bin_in >= 10^DIGITS), using a compile-time constant compare sized to avoid truncation.
  - Go to SHIFT.
- SHIFT, once per cycle:
  - For every scratch digit >= 5, add 3.
  - Then shift {scratch, bin} left by 1 and decrement the counter.
  - The carry out of the top digit is dropped, giving a mod-10^DIGITS result.
  - After the IN_WIDTH-th shift: load bcd_out from scratch, load overflow_out, set valid_out = 1, and go to DONE.
- DONE:
  - valid_out stays high; bcd_out and overflow_out are stable until valid_out && ready_in.
  - In that handshake cycle valid_out clears and state goes to IDLE.
  - No combinational path from ready_in to ready_out. A new input can therefore be accepted no earlier than the cycle after the output handshake.
- Latency: accept edge at cycle T → valid_out high from cycle T+IN_WIDTH+1.
  - With ready_in held high, throughput is one conversion per IN_WIDTH+2 cycles.
- Output hold: bcd_out and overflow_out hold their last value through IDLE and SHIFT; they change only on the SHIFT→DONE load and on reset.
- Input rules:
  - valid_in is ignored outside IDLE.
  - bin_in need only be stable in the accept cycle.
- Boundaries:
  - bin_in = 0 → all-zero BCD.
  - bin_in = 2^IN_WIDTH−1 converts correctly when DIGITS is sufficient.
  - IN_WIDTH = 1 → single shift cycle.

Optional Feature:
- Macro: BIN_TO_BCD_ASCII_EN.
- When defined, add output ascii_out (8*DIGITS bits, digit 0 in [7:0]), registered with bcd_out.
  - Each byte = 8'h30 + digit.
  - Leading-zero digits are replaced with 8'h20 (space); the units digit is never blanked.
  - ascii_out resets to all 8'h20 except the units byte, which is 8'h30.
- When not defined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- IN_WIDTH=8, DIGITS=3, ready_in=1: bin_in=180 → after 9 cycles bcd_out=12'h180, overflow_out=0, valid_out high for 1 cycle.
- Sweep bin_in=0,9,10,99,100,255 → bcd_out=12'h000,12'h009,12'h010,12'h099,12'h100,12'h255; ready_out low during SHIFT/DONE, high otherwise.
- IN_WIDTH=8, DIGITS=2: bin_in=180 → bcd_out=8'h80, overflow_out=1; bin_in=99 → 8'h99, overflow_out=0.
- Backpressure: ready_in=0 for 5 cycles after valid_out rises → valid_out and bcd_out held constant, ready_out=0, valid_in pulses ignored; ready_in=1 → valid_out drops next cycle, ready_out=1.
- Reset: rst_n_in low for 1 cycle in the 4th SHIFT cycle of bin_in=200 → next cycle bcd_out=0, valid_out=0, ready_out=1, and no result is ever emitted; a new bin_in=37 then yields 12'h037.
- BIN_TO_BCD_ASCII_EN defined: bin_in=7 → ascii_out=24'h202037; bin_in=105 → 24'h313035; bin_in=0 → 24'h202030.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per cycle; optional ASCII output under BIN_TO_BCD_ASCII_EN.
// Latency: accept edge T -> valid_out high after edge T+IN_WIDTH; one conversion per IN_WIDTH+2 cycles with ready_in high.
// Backpressure: result held in DONE until ready_in; ready_out is purely state-based (no ready_in -> ready_out path).
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [IN_WIDTH-1:0]   bin_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow_out,
    output logic                  valid_out,
    input  logic                  ready_in
`ifdef BIN_TO_BCD_ASCII_EN
    ,
    output logic [8*DIGITS-1:0]   ascii_out
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);

    // 10^DIGITS needs up to 34 bits for DIGITS=10, so compare in 64 bits.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IN_WIDTH-1:0] sh_q;
    logic [IN_WIDTH-1:0] sh_nxt;
    logic [BW-1:0]       scr_q;
    logic [BW-1:0]       scr_adj;
    logic [BW-1:0]       scr_nxt;
    logic [CW-1:0]       cnt_q;
    logic                ovf_q;
    logic [63:0]         bin_ext;
    logic                accept;
    logic                last_shift;
    logic                unused_carry;

    assign bin_ext    = 64'(bin_in);
    assign accept     = valid_in && ready_out;
    assign last_shift = (cnt_q == CW'(1));

    // Add-3 correction on every digit that would overflow past 9 when doubled.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit shifted out of the top digit is dropped, leaving value mod 10^DIGITS.
    assign {unused_carry, scr_nxt, sh_nxt} = {scr_adj, sh_q, 1'b0};

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_in)   state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    if (ready_in)   state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state_q == IDLE);
        valid_out = (state_q == DONE);
    end

`ifdef BIN_TO_BCD_ASCII_EN
    function automatic logic [8*DIGITS-1:0] ascii_rst_val();
        logic [8*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[8*i +: 8] = (i == 0) ? 8'h30 : 8'h20;
        end
        return r;
    endfunction

    localparam logic [8*DIGITS-1:0] ASCII_RST = ascii_rst_val();

    logic [8*DIGITS-1:0] ascii_nxt;
    logic                ascii_lead;

    // Blank leading zeros from the top digit down; the units digit always prints.
    always_comb begin
        ascii_nxt  = '0;
        ascii_lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            ascii_lead = ascii_lead && (scr_nxt[4*i +: 4] == 4'd0);
            ascii_nxt[8*i +: 8] = ascii_lead ? 8'h20 : {4'h3, scr_nxt[4*i +: 4]};
        end
        ascii_nxt[7:0] = {4'h3, scr_nxt[3:0]};
    end
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sh_q         <= '0;
            scr_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            bcd_out      <= '0;
            overflow_out <= 1'b0;
`ifdef BIN_TO_BCD_ASCII_EN
            ascii_out    <= ASCII_RST;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sh_q  <= bin_in;
                        scr_q <= '0;
                        cnt_q <= CW'(IN_WIDTH);
                        ovf_q <= (bin_ext >= LIMIT);
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_nxt;
                    scr_q <= scr_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_shift) begin
                        bcd_out      <= scr_nxt;
                        overflow_out <= ovf_q;
`ifdef BIN_TO_BCD_ASCII_EN
                        ascii_out    <= ascii_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: 8-bit/3-digit main instance, 2-digit overflow instance, 1-bit single-shift instance.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  bin;
    logic        vin;
    logic        rdy_i;

    logic        rdy_o, ovf, vout;
    logic [11:0] bcd;
    logic        rdy2, ovf2, vout2;
    logic [7:0]  bcd2;
    logic        bin1;
    logic        rdy1, ovf1, vout1;
    logic [3:0]  bcd1;
`ifdef BIN_TO_BCD_ASCII_EN
    logic [23:0] ascii;
    logic [15:0] ascii2;
    logic [7:0]  ascii1;
`endif

    int tests = 0;
    int fails = 0;

    assign bin1 = bin[0];

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .bin_in(bin), .valid_in(vin), .ready_out(rdy_o),
        .bcd_out(bcd), .overflow_out(ovf), .valid_out(vout), .ready_in(rdy_i)
`ifdef BIN_TO_BCD_ASCII_EN
        , .ascii_out(ascii)
`endif
    );

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut2 (
        .clk_in(clk), .rst_n_in(rst_n), .bin_in(bin), .valid_in(vin), .ready_out(rdy2),
        .bcd_out(bcd2), .overflow_out(ovf2), .valid_out(vout2), .ready_in(rdy_i)
`ifdef BIN_TO_BCD_ASCII_EN
        , .ascii_out(ascii2)
`endif
    );

    bin_to_bcd_seq #(.IN_WIDTH(1), .DIGITS(1)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .bin_in(bin1), .valid_in(vin), .ready_out(rdy1),
        .bcd_out(bcd1), .overflow_out(ovf1), .valid_out(vout1), .ready_in(rdy_i)
`ifdef BIN_TO_BCD_ASCII_EN
        , .ascii_out(ascii1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept v, then wait (bounded) for the result and leave the DUT in DONE.
    task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] eb,
                           input logic eo, input bit chk1);
        int n;
        bit rdy_low;
        bin = v;
        vin = 1'b1;
        step();
        vin = 1'b0;
        bin = 8'($urandom);
        n = 0;
        rdy_low = 1'b1;
        while (!vout && n < 20) begin
            if (rdy_o) rdy_low = 1'b0;
            step();
            n++;
            if (chk1 && n == 1) begin
                check({tag, "_w1_valid"}, 64'(vout1), 64'd1);
                check({tag, "_w1_bcd"}, 64'(bcd1), 64'(v[0]));
            end
        end
        check({tag, "_latency"}, 64'(n), 64'd8);
        check({tag, "_ready_low_shift"}, 64'(rdy_low), 64'd1);
        check({tag, "_bcd"}, 64'(bcd), 64'(eb));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        check({tag, "_ready_low_done"}, 64'(rdy_o), 64'd0);
    endtask

    task automatic release_out(input string tag);
        rdy_i = 1'b1;
        step();
        check({tag, "_valid_drop"}, 64'(vout), 64'd0);
        check({tag, "_ready_back"}, 64'(rdy_o), 64'd1);
    endtask

    initial begin
        int n;
        bit seen;
        rst_n = 1'b0;
        bin   = '0;
        vin   = 1'b0;
        rdy_i = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        check("rst_ready", 64'(rdy_o), 64'd1);
        check("rst_valid", 64'(vout), 64'd0);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
`ifdef BIN_TO_BCD_ASCII_EN
        check("rst_ascii", 64'(ascii), 64'h202030);
`endif

        convert("v180", 8'd180, 12'h180, 1'b0, 1'b1);
        check("v180_d2_bcd", 64'(bcd2), 64'h80);
        check("v180_d2_ovf", 64'(ovf2), 64'd1);
        release_out("v180");

        convert("v0", 8'd0, 12'h000, 1'b0, 1'b1);
`ifdef BIN_TO_BCD_ASCII_EN
        check("v0_ascii", 64'(ascii), 64'h202030);
`endif
        release_out("v0");
        convert("v9", 8'd9, 12'h009, 1'b0, 1'b0);
        release_out("v9");
        convert("v10", 8'd10, 12'h010, 1'b0, 1'b0);
        release_out("v10");
        convert("v99", 8'd99, 12'h099, 1'b0, 1'b1);
        check("v99_d2_bcd", 64'(bcd2), 64'h99);
        check("v99_d2_ovf", 64'(ovf2), 64'd0);
        release_out("v99");
        convert("v100", 8'd100, 12'h100, 1'b0, 1'b0);
        check("v100_d2_ovf", 64'(ovf2), 64'd1);
        release_out("v100");
        convert("v255", 8'd255, 12'h255, 1'b0, 1'b1);
        check("v255_d2_bcd", 64'(bcd2), 64'h55);
        release_out("v255");
        convert("v7", 8'd7, 12'h007, 1'b0, 1'b0);
`ifdef BIN_TO_BCD_ASCII_EN
        check("v7_ascii", 64'(ascii), 64'h202037);
`endif
        release_out("v7");
        convert("v105", 8'd105, 12'h105, 1'b0, 1'b0);
`ifdef BIN_TO_BCD_ASCII_EN
        check("v105_ascii", 64'(ascii), 64'h313035);
`endif
        release_out("v105");

        // Backpressure: result must hold and new valid_in pulses must be ignored.
        rdy_i = 1'b0;
        convert("bp123", 8'd123, 12'h123, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bin = 8'd5;
            vin = (i % 2 == 0);
            step();
            check("bp_valid_hold", 64'(vout), 64'd1);
            check("bp_bcd_hold", 64'(bcd), 64'h123);
            check("bp_ready_low", 64'(rdy_o), 64'd0);
        end
        vin = 1'b0;
        release_out("bp123");

        // Outputs keep the previous result while the next conversion shifts.
        bin = 8'd45;
        vin = 1'b1;
        step();
        vin = 1'b0;
        step();
        step();
        check("hold_bcd_shift", 64'(bcd), 64'h123);
        check("hold_valid_shift", 64'(vout), 64'd0);
        n = 0;
        while (!vout && n < 20) begin
            step();
            n++;
        end
        check("v45_bcd", 64'(bcd), 64'h045);
        release_out("v45");

        // Reset in the 4th SHIFT cycle discards the conversion.
        bin = 8'd200;
        vin = 1'b1;
        step();
        vin = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_bcd", 64'(bcd), 64'd0);
        check("midrst_valid", 64'(vout), 64'd0);
        check("midrst_ready", 64'(rdy_o), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (vout) seen = 1'b1;
        end
        check("midrst_no_result", 64'(seen), 64'd0);
        convert("v37", 8'd37, 12'h037, 1'b0, 1'b0);
        release_out("v37");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
